// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths and control-bit indices for pipeline stage latches
package pipe_pkg;

  localparam int PIPE_DATA_WIDTH_DEF = 32;
  localparam int PIPE_CTRL_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    BND_IFID  = 2'd0,
    BND_IDEX  = 2'd1,
    BND_EXMEM = 2'd2,
    BND_MEMWB = 2'd3
  } pipe_boundary_e;

  localparam int IFID_DATA_WIDTH  = 64;
  localparam int IFID_CTRL_WIDTH  = 1;
  localparam int IDEX_DATA_WIDTH  = 128;
  localparam int IDEX_CTRL_WIDTH  = 16;
  localparam int EXMEM_DATA_WIDTH = 96;
  localparam int EXMEM_CTRL_WIDTH = 8;
  localparam int MEMWB_DATA_WIDTH = 64;
  localparam int MEMWB_CTRL_WIDTH = 4;

  // M bundle occupies the low bits, WB bundle sits directly above it
  localparam int CTRL_M_MEM_READ    = 0;
  localparam int CTRL_M_MEM_WRITE   = 1;
  localparam int CTRL_M_BRANCH      = 2;
  localparam int CTRL_WB_REG_WRITE  = 3;
  localparam int CTRL_WB_MEM_TO_REG = 4;

  function automatic int boundary_data_width(input pipe_boundary_e bnd);
    case (bnd)
      BND_IFID:  return IFID_DATA_WIDTH;
      BND_IDEX:  return IDEX_DATA_WIDTH;
      BND_EXMEM: return EXMEM_DATA_WIDTH;
      default:   return MEMWB_DATA_WIDTH;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// rtl/pipe_stage_slot.sv - one register slot of the stage chain (valid, data, ctrl)
module pipe_stage_slot
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = PIPE_DATA_WIDTH_DEF,
  parameter int CTRL_WIDTH = PIPE_CTRL_WIDTH_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_load,
  input  logic                  i_flush,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [CTRL_WIDTH-1:0] i_ctrl,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [CTRL_WIDTH-1:0] o_ctrl
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;

  // Flush beats load; a bubble loads all-zero payload so stale data never lingers
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (i_flush) begin
      valid_d = 1'b0;
      data_d  = '0;
      ctrl_d  = '0;
    end else if (i_load) begin
      valid_d = i_valid;
      data_d  = i_valid ? i_data : '0;
      ctrl_d  = i_valid ? i_ctrl : '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_ctrl  = ctrl_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// rtl/pipe_stage_chain.sv - N-slot valid/ready pipeline latch with flush, step gating and occupancy
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int N_STAGES   = 2,
  parameter int DATA_WIDTH = PIPE_DATA_WIDTH_DEF,
  parameter int CTRL_WIDTH = PIPE_CTRL_WIDTH_DEF,
  parameter int OCC_WIDTH  = $clog2(N_STAGES + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_step,
  input  logic [N_STAGES-1:0]   i_flush_mask,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [CTRL_WIDTH-1:0] i_ctrl,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [CTRL_WIDTH-1:0] o_ctrl,
  output logic [N_STAGES-1:0]   o_stage_valid,
  output logic [OCC_WIDTH-1:0]  o_occupancy
);

  logic [N_STAGES-1:0]   slot_v;
  logic [N_STAGES-1:0]   slot_rdy;
  logic [DATA_WIDTH-1:0] slot_d [N_STAGES];
  logic [CTRL_WIDTH-1:0] slot_c [N_STAGES];
  logic [OCC_WIDTH-1:0]  occ;

  // Ready ripples from the output end back toward slot 0
  always_comb begin
    slot_rdy = '0;
    slot_rdy[N_STAGES-1] = !slot_v[N_STAGES-1] | i_ready;
    for (int k = N_STAGES - 2; k >= 0; k--) begin
      slot_rdy[k] = !slot_v[k] | slot_rdy[k+1];
    end
  end

  for (genvar k = 0; k < N_STAGES; k++) begin : g_slot
    logic                  in_v;
    logic [DATA_WIDTH-1:0] in_d;
    logic [CTRL_WIDTH-1:0] in_c;

    if (k == 0) begin : g_head
      assign in_v = i_valid;
      assign in_d = i_data;
      assign in_c = i_ctrl;
    end else begin : g_body
      assign in_v = slot_v[k-1];
      assign in_d = slot_d[k-1];
      assign in_c = slot_c[k-1];
    end

    pipe_stage_slot #(
      .DATA_WIDTH(DATA_WIDTH),
      .CTRL_WIDTH(CTRL_WIDTH)
    ) u_slot (
      .i_clk  (i_clk),
      .i_reset(i_reset),
      .i_load (i_step & slot_rdy[k]),
      .i_flush(i_flush_mask[k]),
      .i_valid(in_v),
      .i_data (in_d),
      .i_ctrl (in_c),
      .o_valid(slot_v[k]),
      .o_data (slot_d[k]),
      .o_ctrl (slot_c[k])
    );
  end

  always_comb begin
    occ = '0;
    for (int k = 0; k < N_STAGES; k++) begin
      occ = occ + OCC_WIDTH'(slot_v[k]);
    end
  end

  // Reset masks o_ready so nothing presented during reset looks accepted
  assign o_ready       = i_step & slot_rdy[0] & !i_reset;
  assign o_valid       = i_step & slot_v[N_STAGES-1];
  assign o_data        = slot_d[N_STAGES-1];
  assign o_ctrl        = slot_v[N_STAGES-1] ? slot_c[N_STAGES-1] : '0;
  assign o_stage_valid = slot_v;
  assign o_occupancy   = occ;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb/tb_pipe_stage_chain.sv - directed self-checking bench for pipe_stage_chain (3 slots)
module tb_pipe_stage_chain;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int CW = 8;
  localparam int OW = 2;

  logic          clk;
  logic          rst;
  logic          step;
  logic [N-1:0]  flush;
  logic          in_valid;
  logic          out_ready_up;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_valid;
  logic          ds_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [N-1:0]  stage_valid;
  logic [OW-1:0] occupancy;

  int checks = 0;
  int failures = 0;

  pipe_stage_chain #(
    .N_STAGES  (N),
    .DATA_WIDTH(DW),
    .CTRL_WIDTH(CW),
    .OCC_WIDTH (OW)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_step       (step),
    .i_flush_mask (flush),
    .i_valid      (in_valid),
    .o_ready      (out_ready_up),
    .i_data       (in_data),
    .i_ctrl       (in_ctrl),
    .o_valid      (out_valid),
    .i_ready      (ds_ready),
    .o_data       (out_data),
    .o_ctrl       (out_ctrl),
    .o_stage_valid(stage_valid),
    .o_occupancy  (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [CW-1:0] cf(input logic [DW-1:0] d);
    return d[CW-1:0] ^ 8'h5A;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d);
    in_valid = v;
    in_data  = d;
    in_ctrl  = cf(d);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; step = 1'b1; flush = '0; ds_ready = 1'b0;
    drive(1'b0, 32'h0);
    tick(); tick();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(out_ready_up), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    rst = 1'b0;

    // streaming
    ds_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h100 + 32'(i));
      #1;
      chk("stream_ready", 64'(out_ready_up), 64'd1);
      tick();
      chk("stream_valid", 64'(out_valid), (i >= 2) ? 64'd1 : 64'd0);
      chk("stream_data", 64'(out_data), (i >= 2) ? 64'(32'h100 + 32'(i - 2)) : 64'd0);
      chk("stream_occ", 64'(occupancy), (i >= 2) ? 64'd3 : 64'(i + 1));
    end
    drive(1'b0, 32'h0);
    tick();
    chk("stream_d3", 64'(out_data), 64'h103);
    chk("stream_occ2", 64'(occupancy), 64'd2);
    tick();
    chk("stream_d4", 64'(out_data), 64'h104);
    chk("stream_ctrl4", 64'(out_ctrl), 64'(cf(32'h104)));
    tick();
    chk("stream_empty", 64'(out_valid), 64'd0);
    chk("stream_ctrl0", 64'(out_ctrl), 64'd0);

    // backpressure
    ds_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, (c < 3) ? 32'h200 + 32'(c) : 32'h203);
      #1;
      chk("bp_ready", 64'(out_ready_up), (c < 3) ? 64'd1 : 64'd0);
      tick();
      chk("bp_occ", 64'(occupancy), (c < 3) ? 64'(c + 1) : 64'd3);
    end
    chk("bp_hold", 64'(out_data), 64'h200);
    ds_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      if (j < 3) drive(1'b1, 32'h203 + 32'(j));
      else drive(1'b0, 32'h0);
      #1;
      chk("bp_full_ready", 64'(out_ready_up), 64'd1);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_out_data", 64'(out_data), 64'(32'h200 + 32'(j)));
      chk("bp_out_ctrl", 64'(out_ctrl), 64'(cf(32'h200 + 32'(j))));
      tick();
    end
    chk("bp_drained", 64'(occupancy), 64'd0);

    // selective flush
    ds_ready = 1'b0;
    drive(1'b1, 32'hA); tick();
    drive(1'b1, 32'hB); tick();
    drive(1'b1, 32'hC); tick();
    drive(1'b0, 32'h0);
    flush = 3'b010;
    tick();
    flush = '0;
    chk("fl_stage", 64'(stage_valid), 64'b101);
    chk("fl_occ", 64'(occupancy), 64'd2);
    chk("fl_out", 64'(out_data), 64'hA);
    tick();
    chk("fl_shift", 64'(stage_valid), 64'b110);
    ds_ready = 1'b1;
    #1;
    chk("fl_outA", 64'(out_data), 64'hA);
    tick();
    chk("fl_outC", 64'(out_data), 64'hC);
    chk("fl_ctrlC", 64'(out_ctrl), 64'(cf(32'hC)));
    tick();
    chk("fl_empty", 64'(occupancy), 64'd0);

    // step freeze
    ds_ready = 1'b0;
    drive(1'b1, 32'h10); tick();
    drive(1'b1, 32'h11); tick();
    drive(1'b0, 32'h0); tick();
    chk("frz_pre", 64'(stage_valid), 64'b110);
    step = 1'b0; ds_ready = 1'b1;
    drive(1'b1, 32'h99);
    for (int c = 0; c < 4; c++) begin
      flush = (c == 2) ? 3'b100 : 3'b000;
      #1;
      chk("frz_ready", 64'(out_ready_up), 64'd0);
      chk("frz_valid", 64'(out_valid), 64'd0);
      chk("frz_stage", 64'(stage_valid), (c < 3) ? 64'b110 : 64'b010);
      tick();
    end
    flush = '0;
    chk("frz_after", 64'(stage_valid), 64'b010);
    chk("frz_occ", 64'(occupancy), 64'd1);
    step = 1'b1;
    drive(1'b0, 32'h0);
    tick();
    chk("frz_out_v", 64'(out_valid), 64'd1);
    chk("frz_out_d", 64'(out_data), 64'h11);
    tick();
    chk("frz_empty", 64'(occupancy), 64'd0);

    // async reset mid-operation
    ds_ready = 1'b0;
    drive(1'b1, 32'h50); tick();
    drive(1'b1, 32'h51); tick();
    drive(1'b1, 32'h52); tick();
    drive(1'b0, 32'h0);
    chk("ar_full", 64'(occupancy), 64'd3);
    #2;
    rst = 1'b1;
    drive(1'b1, 32'h777);
    #1;
    chk("ar_valid", 64'(out_valid), 64'd0);
    chk("ar_data", 64'(out_data), 64'd0);
    chk("ar_ctrl", 64'(out_ctrl), 64'd0);
    chk("ar_occ", 64'(occupancy), 64'd0);
    chk("ar_ready", 64'(out_ready_up), 64'd0);
    tick();
    rst = 1'b0;
    chk("ar_noaccept", 64'(occupancy), 64'd0);
    ds_ready = 1'b1;
    drive(1'b1, 32'h300);
    #1;
    chk("ar_rdy_after", 64'(out_ready_up), 64'd1);
    tick();
    drive(1'b0, 32'h0);
    chk("ar_lat0", 64'(out_valid), 64'd0);
    tick();
    chk("ar_lat1", 64'(out_valid), 64'd0);
    tick();
    chk("ar_lat2_v", 64'(out_valid), 64'd1);
    chk("ar_lat2_d", 64'(out_data), 64'h300);
    tick();

    // flush vs advance collision
    drive(1'b1, 32'h400);
    tick();
    chk("col_pre", 64'(stage_valid), 64'b001);
    drive(1'b0, 32'h0);
    flush = 3'b010;
    tick();
    flush = '0;
    chk("col_stage", 64'(stage_valid), 64'b000);
    chk("col_occ", 64'(occupancy), 64'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("col_never_v", 64'(out_valid), 64'd0);
      chk("col_never_d", 64'(out_data), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Generalised inter-stage pipeline latch: a chain of N_STAGES registered slots carrying a data payload and a control bundle, with valid/ready handshake, per-slot flush and debug step gating.
- Successor to the fixed single-depth, always-advancing stage latches between IF/ID/EX/MEM/WB.
- Adds backpressure (stall without data loss), selective squash of individual slots, and occupancy reporting for the debug unit.

Parameters:
- N_STAGES, 2: number of register slots in the chain; must be >= 1.
- DATA_WIDTH, 32: payload width (PC, ALU result, operands packed by the instantiator).
- CTRL_WIDTH, 16: control bundle width (M/WB control bits); zeroed on bubble or flush.
- OCC_WIDTH, $clog2(N_STAGES+1): occupancy counter width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  reset; asynchronous, active-high.
- i_step  in  1  debug step enable; when 0 the chain is frozen except for flush.
- i_flush_mask  in  N_STAGES  per-slot squash; bit k clears slot k (slot 0 = input side).
- i_valid  in  1  upstream presents an entry.
- o_ready  out  1  chain accepts the entry this cycle.
- i_data  in  DATA_WIDTH  upstream payload.
- i_ctrl  in  CTRL_WIDTH  upstream control bundle.
- o_valid  out  1  last slot holds a valid entry and i_step=1.
- i_ready  in  1  downstream accepts.
- o_data  out  DATA_WIDTH  last-slot payload.
- o_ctrl  out  CTRL_WIDTH  last-slot control bundle; always 0 when the slot is invalid.
- o_stage_valid  out  N_STAGES  per-slot valid bits (debug).
- o_occupancy  out  OCC_WIDTH  number of valid slots.

Behaviour:
- Reset: i_reset=1 immediately, without waiting for a clock edge, clears every slot's valid, data and ctrl. All outputs read 0 while reset is held.
- Slot ready is combinational:
  - rdy[N-1] = !v[N-1] | i_ready.
  - rdy[k] = !v[k] | rdy[k+1].
  - o_ready = i_step & rdy[0].
  - o_valid = i_step & v[N-1].
- Advance: on a clock edge with i_step=1 and rdy[k]=1, slot k loads from slot k-1 (slot 0 loads from i_valid/i_data/i_ctrl).
  - If the incoming entry is invalid, slot k loads valid=0, data=0, ctrl=0 (bubble).
  - A slot whose rdy=0 holds its value.
- Flush: i_flush_mask[k]=1 on an edge gives slot k valid=0, data=0, ctrl=0 after that edge.
  - Flush overrides any advance into slot k; the entry handed over from slot k-1 is discarded, and slot k-1 still vacates.
  - Flush acts even when i_step=0.
- Priority: reset > flush > advance > hold.
- Step low: no transfers. o_ready=0 and o_valid=0, so neither side sees a handshake. Contents are retained.
- Latency and throughput: an entry accepted at edge t reaches o_valid at edge t+N_STAGES-1 (visible after edge t+N_STAGES-1) when unstalled. Sustained throughput is 1 entry/cycle with i_ready=1.
- Ordering: strictly FIFO. No duplication or loss except by explicit flush.
- Full chain with i_ready=1: drain and fill occur in the same cycle, and o_ready stays 1.
- o_occupancy is the popcount of v[]. Range 0..N_STAGES; no wrap.
- Reset deasserted mid-stream: the chain restarts empty. Any upstream entry presented during reset is not accepted.

Decomposition:
- Shared package pipe_pkg holds:
  - default DATA_WIDTH/CTRL_WIDTH constants per stage boundary (IFID, IDEX, EXMEM, MEMWB);
  - CTRL bit-index localparams for the M and WB bundles.
- One sub-module, pipe_stage_slot: a single slot (valid, data, ctrl registers, flush and load logic).
- pipe_stage_chain generates N_STAGES instances of it plus the ready chain and popcount.

Test Plan (N_STAGES=3, DATA_WIDTH=32, CTRL_WIDTH=8, i_step=1 unless stated):
- Streaming: i_valid=1 with data 0x100..0x104 on consecutive cycles, i_ready=1 -> o_valid rises 2 edges after the first accept with 0x100, then one word per cycle in order. o_occupancy settles at 3.
- Backpressure: hold i_ready=0 while feeding 0x200..0x205 -> exactly 3 accepted, then o_ready=0, o_data=0x200 held. Raise i_ready -> 0x200,0x201,0x202 then 0x203.. emerge with no loss or duplication.
- Selective flush: chain full (0xA,0xB,0xC in slots 2,1,0), i_ready=0, i_valid=0, i_flush_mask=3'b010 for one edge -> o_stage_valid=3'b101 and o_occupancy=2. Next edge 0xC moves into slot 1. Slot 1 ctrl reads 0 in the flushed cycle.
- Step freeze: i_step=0 for 4 cycles with i_valid=1, i_ready=1, chain half full -> o_ready=0, o_valid=0, o_stage_valid unchanged. A flush mask 3'b100 during the freeze still clears slot 2.
- Async reset mid-operation: assert i_reset between clock edges with the chain full -> o_valid, o_data, o_ctrl and o_occupancy are 0 before the next edge. After release, the first accepted entry 0x300 appears after the nominal latency.
- Flush vs advance collision: slot 0 valid (0x400), slot 1 empty, i_flush_mask=3'b010 at the same edge -> slot 0 and slot 1 both empty afterwards, and 0x400 never appears on o_data.
